bcd_display_scheduler: RTL and testbench

//  Sequencing controller for the 3-digit seven-segment binary display path.
//  - Accepts an 8-bit binary value on a load strobe.
//  - Converts it to BCD with a multi-cycle shift-add-3 (double-dabble) FSM.
//  - Holds the result and time-multiplexes the ones/tens/hundreds digits onto

---
 rtl/bcd_display_scheduler.sv | 168 ++++++++++++++++
 tb/tb_bcd_display_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_scheduler
// Description : Loads an 8-bit binary value, converts it to three BCD digits
//               with a multi-cycle double-dabble FSM, and time-multiplexes
//               the digits onto shared active-low anode/segment lines.
//               Optional macro: LEADING_ZERO_BLANK_EN (blank leading zeros).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_scheduler #(
    parameter int TICK_DIV    = 250000,
    parameter int WIDTH_INPUT = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [WIDTH_INPUT-1:0] i_data,
    input  logic                   i_load,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [11:0]            o_bcd,
    output logic [2:0]             o_an,
    output logic [7:0]             o_seg
);

    // Prescaler width; at least one bit so TICK_DIV=1 still elaborates.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH_INPUT-1:0] bin_q, bin_d;
    logic [11:0]            scratch_q, scratch_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [11:0]            bcd_q, bcd_d;
    logic                   done_q, done_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [1:0]             idx_q, idx_d;
    logic [2:0]             an_q, an_d;
    logic [7:0]             seg_q, seg_d;
    logic                   tick;
    logic [11:0]            adj;
    logic [3:0]             digit;

    // Active-low seven-segment pattern for one BCD nibble; >9 blanks.
    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    seg_of = 8'hC0;
            4'd1:    seg_of = 8'hF9;
            4'd2:    seg_of = 8'hA4;
            4'd3:    seg_of = 8'hB0;
            4'd4:    seg_of = 8'h99;
            4'd5:    seg_of = 8'h92;
            4'd6:    seg_of = 8'h82;
            4'd7:    seg_of = 8'hF8;
            4'd8:    seg_of = 8'h80;
            4'd9:    seg_of = 8'h90;
            default: seg_of = 8'hFF;
        endcase
    endfunction

    // Add-3 correction on every scratch nibble that is 5 or more.
    always_comb begin
        adj[3:0]   = (scratch_q[3:0]   >= 4'd5) ? scratch_q[3:0]   + 4'd3 : scratch_q[3:0];
        adj[7:4]   = (scratch_q[7:4]   >= 4'd5) ? scratch_q[7:4]   + 4'd3 : scratch_q[7:4];
        adj[11:8]  = (scratch_q[11:8]  >= 4'd5) ? scratch_q[11:8]  + 4'd3 : scratch_q[11:8];
    end

    // Conversion FSM next-state: IDLE -> SHIFT (8 cycles) -> DONE -> IDLE.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_load) begin
                    bin_d     = i_data;
                    scratch_d = 12'h000;
                    cnt_d     = 3'd0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {scratch_d, bin_d} = {adj[10:0], bin_q, 1'b0};
                cnt_d              = cnt_q + 3'd1;
                if (cnt_q == 3'(WIDTH_INPUT - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Result and done pulse become visible together on the next edge.
                bcd_d   = scratch_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scan prescaler, digit index and registered anode/segment drive.
    always_comb begin
        tick    = (presc_q == PW'(TICK_DIV - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (tick) begin
            idx_d = (idx_q >= 2'd2) ? 2'd0 : idx_q + 2'd1;
        end else if (idx_q == 2'd3) begin
            idx_d = 2'd0;
        end
        // Decode from next-state values so outputs track index and o_bcd
        // changes on the same edge that updates them.
        case (idx_d)
            2'd1:    begin an_d = 3'b101; digit = bcd_d[7:4];  end
            2'd2:    begin an_d = 3'b011; digit = bcd_d[11:8]; end
            default: begin an_d = 3'b110; digit = bcd_d[3:0];  end
        endcase
        seg_d = seg_of(digit);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_d == 2'd2 && bcd_d[11:8] == 4'd0) begin
            seg_d = 8'hFF;
        end
        if (idx_d == 2'd1 && bcd_d[11:8] == 4'd0 && bcd_d[7:4] == 4'd0) begin
            seg_d = 8'hFF;
        end
`endif
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            bin_q     <= '0;
            scratch_q <= 12'h000;
            cnt_q     <= 3'd0;
            bcd_q     <= 12'h000;
            done_q    <= 1'b0;
            presc_q   <= '0;
            idx_q     <= 2'd0;
            an_q      <= 3'b110;
            seg_q     <= 8'hC0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign o_busy = (state_q == S_SHIFT);
    assign o_done = done_q;
    assign o_bcd  = bcd_q;
    assign o_an   = an_q;
    assign o_seg  = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_display_scheduler
// Description : Directed self-checking bench for bcd_display_scheduler
//               (TICK_DIV=4). Honours LEADING_ZERO_BLANK_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_display_scheduler;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        load  = 1'b0;
    logic [7:0]  data  = 8'h00;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic [2:0]  an;
    logic [7:0]  seg;

    int n_cmp = 0;
    int n_err = 0;

    bcd_display_scheduler #(.TICK_DIV(4), .WIDTH_INPUT(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data  (data),
        .i_load  (load),
        .o_busy  (busy),
        .o_done  (done),
        .o_bcd   (bcd),
        .o_an    (an),
        .o_seg   (seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-clock load strobe, then wait (bounded) for o_done.
    task automatic convert(input logic [7:0] v, output int lat, output int bcyc);
        data = v;
        load = 1'b1;
        step(1);
        load = 1'b0;
        lat  = 0;
        bcyc = 0;
        while (!done && lat < 30) begin
            if (busy) bcyc++;
            step(1);
            lat++;
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Synchronise to the start of the ones slot, then walk one full scan.
    task automatic scan_check(input string tag, input logic [7:0] s0,
                              input logic [7:0] s1, input logic [7:0] s2);
        logic [2:0] prev;
        int k;
        k    = 0;
        prev = an;
        step(1);
        while (!(prev == 3'b011 && an == 3'b110) && k < 20) begin
            prev = an;
            step(1);
            k++;
        end
        chk({tag, "_sync"}, 32'(k < 20), 32'd1);
        chk({tag, "_an0"},  an,  3'b110);
        chk({tag, "_seg0"}, seg, s0);
        step(3);
        chk({tag, "_an0_hold"}, an, 3'b110);
        step(1);
        chk({tag, "_an1"},  an,  3'b101);
        chk({tag, "_seg1"}, seg, s1);
        step(4);
        chk({tag, "_an2"},  an,  3'b011);
        chk({tag, "_seg2"}, seg, s2);
        step(4);
        chk({tag, "_an0b"},  an,  3'b110);
        chk({tag, "_seg0b"}, seg, s0);
    endtask

    initial begin
        int lat;
        int bcyc;
        int ndone;
        logic [7:0]  dv [6];
        logic [11:0] ev [6];
        dv = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd255};
        ev = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h255};

        // Reset held for three clocks.
        rst_n = 1'b0;
        step(3);
        chk("rst_bcd",  bcd,  12'h000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_an",   an,   3'b110);
        chk("rst_seg",  seg,  8'hC0);
        rst_n = 1'b1;
        step(1);

        // Latency and busy window for 255.
        convert(8'd255, lat, bcyc);
        chk("lat_255",  lat,  9);
        chk("busy_255", bcyc, 8);
        chk("bcd_255",  bcd,  12'h255);
        chk("busy_at_done", busy, 1'b0);
        step(1);
        chk("done_pulse_1clk", done, 1'b0);

        // Directed values.
        for (int i = 0; i < 6; i++) begin
            convert(dv[i], lat, bcyc);
            chk("dir_lat", lat, 9);
            chk("dir_bcd", bcd, ev[i]);
        end

        // Full sweep against the arithmetic reference.
        for (int v = 0; v < 256; v++) begin
            convert(8'(v), lat, bcyc);
            chk("sweep_bcd", bcd, ref_bcd(v));
        end

        // Scan of 137: ones 7, tens 3, hundreds 1.
        convert(8'd137, lat, bcyc);
        chk("bcd_137", bcd, 12'h137);
        scan_check("scan137", 8'hF8, 8'hB0, 8'hF9);

        // Leading zeros on 007, and interior zero on 105.
        convert(8'd7, lat, bcyc);
        chk("bcd_007", bcd, 12'h007);
`ifdef LEADING_ZERO_BLANK_EN
        scan_check("scan007", 8'hF8, 8'hFF, 8'hFF);
`else
        scan_check("scan007", 8'hF8, 8'hC0, 8'hC0);
`endif
        convert(8'd105, lat, bcyc);
        chk("bcd_105", bcd, 12'h105);
        scan_check("scan105", 8'h92, 8'hC0, 8'hF9);

        // Load of 42 while converting 200 must be ignored.
        data = 8'd200;
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(2);
        chk("busy_mid", busy, 1'b1);
        data = 8'd42;
        load = 1'b1;
        step(3);
        load = 1'b0;
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            if (done) ndone++;
            step(1);
        end
        chk("ignore_ndone", ndone, 1);
        chk("ignore_bcd",   bcd,   12'h200);

        // Reset in the fourth SHIFT cycle aborts the conversion.
        data = 8'd99;
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(3);
        chk("abort_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        step(1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_bcd",  bcd,  12'h000);
        chk("abort_an",   an,   3'b110);
        chk("abort_seg",  seg,  8'hC0);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            if (done) ndone++;
            step(1);
        end
        chk("abort_ndone", ndone, 0);
        chk("abort_bcd_after", bcd, 12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
